// File: rtl/i2c_slave_port.sv
// I2C target: filtered SCL/SDA, START/STOP detect, 7-bit address match,
// byte receive with ACK, byte transmit from local logic. Open-drain SDA.
module i2c_slave_port #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
);

  localparam int CW = 3;
  localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
  } state_t;

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic [1:0] raw;
  logic [1:0] filt;
  logic [1:0] filt_q;
  logic [1:0][CW-1:0] fcnt;

  logic scl_f;
  logic sda_f;
  logic scl_rise;
  logic scl_fall;
  logic start_c;
  logic stop_c;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       sda_oe, sda_oe_n;
  logic       rw, rw_n;
  logic       first, first_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n;
  logic       rx_first_n;

  // Index 1 is SCL, index 0 is SDA.
  assign raw = {scl_sync[1], sda_sync[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl};
      sda_sync <= {sda_sync[0], i2c_sda};
    end
  end

  // A filtered level flips only after FILTER_LEN consecutive
  // samples disagree with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt   <= 2'b11;
      filt_q <= 2'b11;
      fcnt   <= '0;
    end else begin
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CMAX) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_f    = filt[1];
  assign sda_f    = filt[0];
  assign scl_rise = filt[1] & ~filt_q[1];
  assign scl_fall = ~filt[1] & filt_q[1];
  assign start_c  = filt_q[0] & ~filt[0] & scl_f & filt_q[1];
  assign stop_c   = ~filt_q[0] & filt[0] & scl_f & filt_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      sda_oe   <= 1'b0;
      rw       <= 1'b0;
      first    <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      sda_oe   <= sda_oe_n;
      rw       <= rw_n;
      first    <= first_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      rx_first <= rx_first_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shreg_n    = shreg;
    sda_oe_n   = sda_oe;
    rw_n       = rw;
    first_n    = first;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rx_first_n = 1'b0;
    tx_load    = 1'b0;
    if (stop_c) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      cnt_n    = '0;
    end else if (start_c) begin
      state_n  = ADDR;
      sda_oe_n = 1'b0;
      cnt_n    = '0;
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise) begin
            shreg_n = {shreg[6:0], sda_f};
            if (cnt == 4'd7) begin
              cnt_n = '0;
              if (shreg[6:0] == SLAVE_ADDR) begin
                state_n = ADDR_ACK;
                rw_n    = sda_f;
                first_n = 1'b1;
              end else begin
                state_n = IGNORE;
              end
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = RX;
              cnt_n    = '0;
            end
          end else if (scl_rise && sda_oe && rw) begin
            // ACK stays driven; the TX fall below replaces it with the MSB.
            tx_load = 1'b1;
            shreg_n = tx_data;
            cnt_n   = '0;
            state_n = TX;
          end
        end
        RX: begin
          if (scl_rise) begin
            shreg_n = {shreg[6:0], sda_f};
            if (cnt == 4'd7) begin
              cnt_n      = '0;
              rx_data_n  = {shreg[6:0], sda_f};
              rx_valid_n = 1'b1;
              rx_first_n = first;
              first_n    = 1'b0;
              state_n    = RX_ACK;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = RX;
            end
          end
        end
        TX: begin
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_oe_n = 1'b0;
              state_n  = TX_ACK;
            end else begin
              sda_oe_n = ~shreg[7];
              shreg_n  = {shreg[6:0], 1'b0};
              cnt_n    = cnt + 4'd1;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              tx_load = 1'b1;
              shreg_n = tx_data;
              cnt_n   = '0;
              state_n = TX;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == ADDR_ACK) || (state == RX) ||
                (state == RX_ACK) || (state == TX) ||
                (state == TX_ACK);

  // Reset gates the driver directly so SDA lets go immediately.
  assign i2c_sda = (sda_oe && !reset) ? 1'b0 : 1'bz;

endmodule
